// File: rtl/icache_refill_ctrl_pkg.sv
// Shared constants and FSM state type for the I-cache refill controller.
// Optional perf counters in the top level are enabled with IREFILL_PERF_EN.
package icache_refill_ctrl_pkg;

  localparam int unsigned INST_ADDR_WIDTH = 32;
  localparam int unsigned IREFILL_LINE_W  = 128;
  localparam int unsigned IREFILL_OFF_W   = $clog2(IREFILL_LINE_W / 8);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_RECV  = 3'd2,
    ST_FILL  = 3'd3,
    ST_DRAIN = 3'd4
  } irefill_state_e;

endpackage

// File: rtl/icache_refill_ctrl_line_asm.sv
// Beat counter and line register: beat k of a burst lands in line[BEAT_W*k +: BEAT_W].
module irefill_line_asm
  import icache_refill_ctrl_pkg::*;
#(
  parameter int unsigned BEAT_W = 32,
  parameter int unsigned BEATS  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      beat_en,
  input  logic                      store_en,
  input  logic [BEAT_W-1:0]         beat_data,
  output logic [BEAT_W*BEATS-1:0]   line,
  output logic                      last_beat
);

  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      line <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (beat_en) begin
      cnt <= cnt + 1'b1;
      if (store_en) begin
        line[cnt*BEAT_W +: BEAT_W] <= beat_data;
      end
    end
  end

  assign last_beat = (cnt == CNT_W'(BEATS - 1));

endmodule

// File: rtl/icache_refill_ctrl.sv
// I-cache miss sequencer: one 4-beat burst per miss, line fill plus fetch response.
// Define IREFILL_PERF_EN to build the miss/abort/busy performance counters.
module icache_refill_ctrl
  import icache_refill_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = INST_ADDR_WIDTH,
  parameter int unsigned BEAT_W = 32,
  parameter int unsigned BEATS  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         miss_valid,
  input  logic [ADDR_W-1:0]            miss_paddr,
  output logic                         miss_ready,
  input  logic                         abort,
  output logic                         mem_req_valid,
  output logic [ADDR_W-1:0]            mem_req_addr,
  input  logic                         mem_req_ready,
  input  logic                         mem_resp_valid,
  input  logic [BEAT_W-1:0]            mem_resp_data,
  output logic                         fill_valid,
  output logic [ADDR_W-IREFILL_OFF_W-1:0] fill_tag,
  output logic [BEAT_W*BEATS-1:0]      fill_data,
  output logic                         resp_valid,
  output logic [31:0]                  perf_miss,
  output logic [31:0]                  perf_abort,
  output logic [31:0]                  perf_busy
);

  irefill_state_e state, state_nxt;

  logic [ADDR_W-IREFILL_OFF_W-1:0] base_q;
  logic idle_ready;
  logic accept;
  logic beat_en;
  logic store_en;
  logic last_beat;
  logic unused_offset;

  assign unused_offset = ^miss_paddr[IREFILL_OFF_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      base_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        base_q <= miss_paddr[ADDR_W-1:IREFILL_OFF_W];
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    idle_ready    = 1'b0;
    accept        = 1'b0;
    mem_req_valid = 1'b0;
    beat_en       = 1'b0;
    store_en      = 1'b0;
    fill_valid    = 1'b0;
    resp_valid    = 1'b0;
    case (state)
      ST_IDLE: begin
        idle_ready = 1'b1;
        if (miss_valid && !abort) begin
          accept    = 1'b1;
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          state_nxt = abort ? ST_DRAIN : ST_RECV;
        end else if (abort) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_RECV: begin
        beat_en  = mem_resp_valid;
        store_en = 1'b1;
        // An abort that coincides with the final beat leaves nothing to drain.
        if (abort) begin
          state_nxt = (mem_resp_valid && last_beat) ? ST_IDLE : ST_DRAIN;
        end else if (mem_resp_valid && last_beat) begin
          state_nxt = ST_FILL;
        end
      end
      ST_DRAIN: begin
        beat_en = mem_resp_valid;
        if (mem_resp_valid && last_beat) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_FILL: begin
        fill_valid = 1'b1;
        resp_valid = !abort;
        state_nxt  = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Reset holds miss_ready low even though the state register already reads IDLE.
  assign miss_ready   = idle_ready & rst_n;
  assign mem_req_addr = {base_q, {IREFILL_OFF_W{1'b0}}};
  assign fill_tag     = base_q;

  irefill_line_asm #(
    .BEAT_W (BEAT_W),
    .BEATS  (BEATS)
  ) u_line_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (accept),
    .beat_en   (beat_en),
    .store_en  (store_en),
    .beat_data (mem_resp_data),
    .line      (fill_data),
    .last_beat (last_beat)
  );

`ifdef IREFILL_PERF_EN
  logic abort_evt;

  assign abort_evt = abort && ((state == ST_REQ) || (state == ST_RECV));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_miss  <= '0;
      perf_abort <= '0;
      perf_busy  <= '0;
    end else begin
      if (accept)            perf_miss  <= perf_miss + 32'd1;
      if (abort_evt)         perf_abort <= perf_abort + 32'd1;
      if (state != ST_IDLE)  perf_busy  <= perf_busy + 32'd1;
    end
  end
`else
  assign perf_miss  = '0;
  assign perf_abort = '0;
  assign perf_busy  = '0;
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Bench for icache_refill_ctrl: directed vector table, reset-in-flight sequence, random run vs model.
module tb_icache_refill_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         miss_valid = 1'b0;
  logic [31:0]  miss_paddr = '0;
  logic         miss_ready;
  logic         abort = 1'b0;
  logic         mem_req_valid;
  logic [31:0]  mem_req_addr;
  logic         mem_req_ready = 1'b0;
  logic         mem_resp_valid = 1'b0;
  logic [31:0]  mem_resp_data = '0;
  logic         fill_valid;
  logic [27:0]  fill_tag;
  logic [127:0] fill_data;
  logic         resp_valid;
  logic [31:0]  perf_miss, perf_abort, perf_busy;

`ifdef IREFILL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  icache_refill_ctrl #(.ADDR_W(32), .BEAT_W(32), .BEATS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .miss_valid(miss_valid), .miss_paddr(miss_paddr), .miss_ready(miss_ready),
    .abort(abort),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .fill_valid(fill_valid), .fill_tag(fill_tag), .fill_data(fill_data), .resp_valid(resp_valid),
    .perf_miss(perf_miss), .perf_abort(perf_abort), .perf_busy(perf_busy)
  );

  always #5 clk = ~clk;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic         mv;
    logic [31:0]  pa;
    logic         ab, rr, rv;
    logic [31:0]  rd;
    logic         e_mr, e_rq, e_fv, e_rv;
    logic [31:0]  e_addr;
    logic [27:0]  e_tag;
    logic [127:0] e_line;
  } vec_t;

  vec_t         tbl[$];
  logic [31:0]  cur_addr;
  logic [127:0] cur_line;

  task automatic add(input logic mv, input logic [31:0] pa, input logic ab, input logic rr,
                     input logic rv, input logic [31:0] rd,
                     input logic e_mr, input logic e_rq, input logic e_fv, input logic e_rv);
    vec_t v;
    v.mv = mv; v.pa = pa; v.ab = ab; v.rr = rr; v.rv = rv; v.rd = rd;
    v.e_mr = e_mr; v.e_rq = e_rq; v.e_fv = e_fv; v.e_rv = e_rv;
    v.e_addr = cur_addr; v.e_tag = cur_addr[31:4]; v.e_line = cur_line;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic mv, input logic [31:0] pa, input logic ab, input logic rr,
                       input logic rv, input logic [31:0] rd);
    miss_valid = mv; miss_paddr = pa; abort = ab;
    mem_req_ready = rr; mem_resp_valid = rv; mem_resp_data = rd;
  endtask

  // Reference model: transaction-level view of an outstanding refill.
  bit          m_req, m_cancel, m_fill;
  int          m_left;
  logic [31:0] m_beats[$];
  logic [31:0] m_addr;
  logic [31:0] m_miss, m_abort, m_busy;

  function automatic logic [127:0] m_line();
    logic [127:0] ln = '0;
    foreach (m_beats[i]) ln[32*i +: 32] = m_beats[i];
    return ln;
  endfunction

  int unsigned exp_busy;

  initial begin
    // Test 1: zero-wait refill of 0x8000_0024
    cur_addr = 32'h8000_0020;
    cur_line = 128'h00000044_00000033_00000022_00000011;
    add(1, 32'h8000_0024, 0, 0, 0, 0,       1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0,                   0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 32'h11,              0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 32'h22,              0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 32'h33,              0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 32'h44,              0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,                   0, 0, 1, 1);
    // Miss under abort is dropped; stray beat in IDLE ignored
    add(1, 32'h4000_0000, 1, 0, 1, 32'hdead, 1, 0, 0, 0);
    // Test 2: request stalled 3 cycles
    cur_addr = 32'h1234_5670;
    cur_line = 128'h000000a4_000000a3_000000a2_000000a1;
    add(1, 32'h1234_567c, 0, 1, 0, 0,       1, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0,                   0, 1, 0, 0);
    for (int i = 1; i <= 4; i++) add(0, 0, 0, 0, 1, 32'ha0 + 32'(i), 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,                   0, 0, 1, 1);
    // Test 3: abort in REQ before handshake
    cur_addr = 32'hcafe_0000;
    add(1, 32'hcafe_0008, 0, 0, 0, 0,       1, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0,                   0, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0,                   1, 0, 0, 0);
    // Test 4: abort after beat 1, drain beats 2-3
    cur_addr = 32'h0000_1230;
    add(1, 32'h0000_123f, 0, 0, 0, 0,       1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0,                   0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 32'hd0,              0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 32'hd1,              0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0,                   0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 32'hd2,              0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,                   0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 32'hd3,              0, 0, 0, 0);
    // Test 5: next miss right after drain; abort during FILL
    cur_addr = 32'hffff_fff0;
    cur_line = 128'h000000e3_000000e2_000000e1_000000e0;
    add(1, 32'hffff_ffff, 0, 0, 0, 0,       1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0,                   0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 32'he0,              0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 32'he1,              0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,                   0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 32'he2,              0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 32'he3,              0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0,                   0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0,                   1, 0, 0, 0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_miss_ready", 128'(miss_ready), 128'(0));
    chk("rst_req_valid",  128'(mem_req_valid), 128'(0));
    chk("rst_fill_valid", 128'(fill_valid), 128'(0));
    chk("rst_fill_data",  fill_data, 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    exp_busy = 0;
    foreach (tbl[i]) begin
      @(posedge clk); #1;
      drive(tbl[i].mv, tbl[i].pa, tbl[i].ab, tbl[i].rr, tbl[i].rv, tbl[i].rd);
      @(negedge clk);
      if (!tbl[i].e_mr) exp_busy++;
      chk($sformatf("v%0d_miss_ready", i), 128'(miss_ready), 128'(tbl[i].e_mr));
      chk($sformatf("v%0d_req_valid", i),  128'(mem_req_valid), 128'(tbl[i].e_rq));
      chk($sformatf("v%0d_fill_valid", i), 128'(fill_valid), 128'(tbl[i].e_fv));
      chk($sformatf("v%0d_resp_valid", i), 128'(resp_valid), 128'(tbl[i].e_rv));
      if (tbl[i].e_rq) chk($sformatf("v%0d_req_addr", i), 128'(mem_req_addr), 128'(tbl[i].e_addr));
      if (tbl[i].e_fv) begin
        chk($sformatf("v%0d_fill_tag", i),  128'(fill_tag), 128'(tbl[i].e_tag));
        chk($sformatf("v%0d_fill_data", i), fill_data, tbl[i].e_line);
      end
    end
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0);
    chk("perf_miss_tbl",  128'(perf_miss),  PERF ? 128'(5) : 128'(0));
    chk("perf_abort_tbl", 128'(perf_abort), PERF ? 128'(2) : 128'(0));
    chk("perf_busy_tbl",  128'(perf_busy),  PERF ? 128'(exp_busy) : 128'(0));

    // Reset in RECV after two beats
    @(posedge clk); #1 drive(1, 32'h5555_0004, 0, 0, 0, 0);
    @(posedge clk); #1 drive(0, 0, 0, 1, 0, 0);
    @(posedge clk); #1 drive(0, 0, 0, 0, 1, 32'h1);
    @(posedge clk); #1 drive(0, 0, 0, 0, 1, 32'h2);
    @(posedge clk); #1 drive(0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rr_miss_ready", 128'(miss_ready), 128'(0));
    chk("rr_req_valid",  128'(mem_req_valid), 128'(0));
    chk("rr_req_addr",   128'(mem_req_addr), 128'(0));
    chk("rr_fill_valid", 128'(fill_valid), 128'(0));
    chk("rr_resp_valid", 128'(resp_valid), 128'(0));
    chk("rr_fill_tag",   128'(fill_tag), 128'(0));
    chk("rr_fill_data",  fill_data, 128'(0));
    chk("rr_perf", 128'({perf_miss, perf_abort, perf_busy}), 128'(0));
    @(posedge clk); #1 drive(0, 0, 0, 0, 1, 32'h3);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1 drive(0, 0, 0, 0, 1, 32'h4 + 32'(i));
      @(negedge clk);
      chk("stray_idle", 128'({miss_ready, mem_req_valid, fill_valid, resp_valid}), 128'(4'b1000));
    end

    // Random run; model and DUT both start from idle with counters at the values above
    m_req = 0; m_cancel = 0; m_fill = 0; m_left = 0; m_beats.delete(); m_addr = '0;
    m_miss = '0; m_abort = '0; m_busy = 32'd3;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit idle;
      @(posedge clk); #1;
      drive($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 15) == 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 6, $urandom);
      @(negedge clk);
      idle = !m_req && (m_left == 0) && !m_fill;
      chk("rnd_miss_ready", 128'(miss_ready), 128'(idle));
      chk("rnd_req_valid",  128'(mem_req_valid), 128'(m_req));
      chk("rnd_fill_valid", 128'(fill_valid), 128'(m_fill));
      chk("rnd_resp_valid", 128'(resp_valid), 128'(m_fill && !abort));
      if (m_req) chk("rnd_req_addr", 128'(mem_req_addr), 128'(m_addr));
      if (m_fill) begin
        chk("rnd_fill_tag",  128'(fill_tag), 128'(m_addr[31:4]));
        chk("rnd_fill_data", fill_data, m_line());
      end
      chk("rnd_perf_miss",  128'(perf_miss),  PERF ? 128'(m_miss)  : 128'(0));
      chk("rnd_perf_abort", 128'(perf_abort), PERF ? 128'(m_abort) : 128'(0));
      // busy in model: first three post-reset idle cycles above were IDLE, so start from 0
      if (cyc == 0) m_busy = '0;
      chk("rnd_perf_busy",  128'(perf_busy),  PERF ? 128'(m_busy)  : 128'(0));
      if (!idle) m_busy++;
      if (idle) begin
        if (miss_valid && !abort) begin
          m_req = 1; m_addr = {miss_paddr[31:4], 4'h0}; m_beats.delete(); m_miss++;
        end
      end else if (m_req) begin
        if (mem_req_ready) begin
          m_req = 0; m_left = 4; m_cancel = abort;
          if (abort) m_abort++;
        end else if (abort) begin
          m_req = 0; m_abort++;
        end
      end else if (m_left > 0) begin
        if (mem_resp_valid) begin
          if (!m_cancel) m_beats.push_back(mem_resp_data);
          m_left--;
        end
        if (abort && !m_cancel) begin
          m_cancel = 1; m_abort++;
        end
        if (m_left == 0 && !m_cancel) m_fill = 1;
      end else begin
        m_fill = 0;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
